// File: rtl/oldland_bus_pkg.sv
// Shared types and constants for the oldland two-master memory bus arbiter
// and its watchdog timer.
package oldland_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Instruction fetches always move a full word.
  localparam logic [3:0] I_BYTESEL = 4'b1111;

  // Counter width able to hold 0..cycles, never narrower than one bit.
  function automatic int unsigned timer_width(int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/oldland_bus_timer.sv
// Clearable cycle counter flagging the last permitted cycle of a bus transfer.
// A limit of zero never expires.
module oldland_bus_timer
  import oldland_bus_pkg::*;
#(
  parameter int unsigned limit = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned Width = timer_width(limit);
  localparam logic [Width-1:0] LastCount = (limit == 0) ? '0 : Width'(limit - 1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign expired = (limit != 0) && (count_q == LastCount);

endmodule

// File: rtl/oldland_bus_arbiter.sv
// Round-robin arbiter merging the instruction and data buses onto one memory
// bus, with registered request/response paths and a transfer watchdog.
module oldland_bus_arbiter
  import oldland_bus_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,

  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,

  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,

  output logic        timeout
);

  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  grant_t      last_grant_q, last_grant_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  bytesel_q, bytesel_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_val_q, wr_val_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;

  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;

  oldland_bus_timer #(
    .limit (timeout_cycles)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    bytesel_d    = bytesel_q;
    wr_en_d      = wr_en_q;
    wr_val_d     = wr_val_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    timeout_d    = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_access || d_access) begin
          // On a tie the master that did not win last time gets the bus.
          if (i_access && (!d_access || last_grant_q == GNT_D)) begin
            grant_d   = GNT_I;
            addr_d    = i_addr;
            bytesel_d = I_BYTESEL;
            wr_en_d   = 1'b0;
            wr_val_d  = '0;
          end else begin
            grant_d   = GNT_D;
            addr_d    = d_addr;
            bytesel_d = d_bytesel;
            wr_en_d   = d_wr_en;
            wr_val_d  = d_wr_val;
          end
          last_grant_d = grant_d;
          timer_clear  = 1'b1;
          state_d      = XFER;
        end
      end

      XFER: begin
        if (m_error) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (m_ack) begin
          err_d   = 1'b0;
          rdata_d = wr_en_q ? '0 : m_data;
          state_d = RESP;
        end else if (timer_expired) begin
          err_d     = 1'b1;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_D;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
      bytesel_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_val_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      bytesel_q    <= bytesel_d;
      wr_en_q      <= wr_en_d;
      wr_val_q     <= wr_val_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  logic resp_i;
  logic resp_d;

  assign resp_i = (state_q == RESP) && (grant_q == GNT_I);
  assign resp_d = (state_q == RESP) && (grant_q == GNT_D);

  assign m_access  = (state_q == XFER);
  assign m_addr    = addr_q;
  assign m_bytesel = bytesel_q;
  assign m_wr_en   = wr_en_q;
  assign m_wr_val  = wr_val_q;

  assign i_ack   = resp_i && !err_q;
  assign i_error = resp_i && err_q;
  assign i_data  = resp_i ? rdata_q : '0;
  assign d_ack   = resp_d && !err_q;
  assign d_error = resp_d && err_q;
  assign d_data  = resp_d ? rdata_q : '0;
  assign timeout = timeout_q;

endmodule

// File: doc/oldland_bus_arbiter.md
# oldland_bus_arbiter

Two-master, one-slave arbiter that merges the CPU's instruction bus (I$ miss/fill port, read-only) and data bus (D$ miss/fill/writeback port) onto a single memory bus toward the SDRAM/peripheral interconnect. Sits directly downstream of the CPU top-level buses and upstream of the memory controller. Provides round-robin fairness, registered request/response paths and a bus-timeout watchdog that converts hung transfers into bus errors.

## Interface
- timeout_cycles, 1024: XFER cycles without m_ack/m_error before a forced error; 0 disables timeout.
- clk  in  1  CPU clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_access  in  1  instruction-master request, held until i_ack/i_error.
- i_addr  in  30  instruction word address.
- i_data  out  32  read data to instruction master.
- i_ack  out  1  one-cycle completion pulse.
- i_error  out  1  one-cycle error pulse.
- d_access  in  1  data-master request, held until d_ack/d_error.
- d_addr  in  30  data word address.
- d_bytesel  in  4  byte lane enables.
- d_wr_en  in  1  1 = write.
- d_wr_val  in  32  write data.
- d_data  out  32  read data to data master.
- d_ack  out  1  one-cycle completion pulse.
- d_error  out  1  one-cycle error pulse.
- m_access  out  1  memory request, held until termination.
- m_addr  out  30, m_bytesel  out  4, m_wr_en  out  1, m_wr_val  out  32: latched request fields.
- m_data  in  32, m_ack  in  1, m_error  in  1: slave response.
- timeout  out  1  one-cycle pulse when the watchdog terminates a transfer.

## Operation
- FSM: IDLE, XFER, RESP. Reset state IDLE; last_grant resets to D (so I wins the first tie).
- IDLE: if exactly one access high, grant it; if both, grant the master not equal to last_grant. On grant: latch master fields into m_*, set grant/last_grant, clear timer, go XFER.
- I grant drives m_bytesel=4'b1111, m_wr_en=0, m_wr_val=0.
- XFER: m_access=1. On m_error: go RESP with error. Else on m_ack: latch m_data, go RESP with ack. Else if timeout_cycles!=0 and timer==timeout_cycles-1: go RESP with error, pulse timeout. Else timer++.
- Simultaneous m_ack and m_error: error wins. Ack on the timeout cycle: ack wins, no timeout pulse.
- RESP: m_access=0; granted master sees x_ack or x_error for exactly one cycle, x_data = latched m_data (0 on error/write). Next state IDLE.
- Master access sampled in IDLE after RESP is treated as a new request (back-to-back line fills legal).
- m_ack/m_error while m_access=0 are ignored (late slave responses after timeout discarded).
- Ungranted master's ack/error/data stay 0.
- m_addr/m_bytesel/m_wr_en/m_wr_val hold last latched values outside XFER; only m_access qualifies them.

## Timing
- Reset values: m_access, m_addr, m_bytesel, m_wr_en, m_wr_val, i_*/d_* outputs, timeout all 0.
- Request high in IDLE at cycle 0 -> m_access at cycle 1.
- m_ack sampled from cycle 1; ack in cycle k -> x_ack in cycle k+1 -> IDLE in cycle k+2.
- Minimum 3 cycles per transfer (zero-wait slave); throughput one transfer per 3 cycles.
- Timeout: with no response, m_access high for exactly timeout_cycles cycles, error pulse the following cycle.
- rst mid-transfer: next cycle IDLE, m_access=0, no ack/error issued, in-flight transfer abandoned; last_grant back to D.
- Master dropping access mid-XFER is illegal; arbiter completes the transfer regardless.

## Structure
- Shared package oldland_bus_pkg: state enum (IDLE/XFER/RESP), grant encoding (GNT_I, GNT_D), I_BYTESEL constant 4'b1111.
- Timer width = $clog2(timeout_cycles+1), minimum 1.
- One natural sub-module: oldland_bus_timer (clear/enable/expired counter), reusable by the debug memory path.

## Test plan
- I only, addr 30'h100, slave acks 2 cycles after m_access, data 32'hDEADBEEF -> m_bytesel=4'hF, m_wr_en=0; i_ack one cycle with i_data=32'hDEADBEEF; d_ack never asserts.
- D write addr 30'h2000, bytesel 4'b0011, val 32'h1234_5678 -> m_* match exactly; d_ack pulse, d_data=0.
- Both request continuously from reset -> grant order I, D, I, D; each master sees its ack every 6 cycles with zero-wait slave.
- Slave asserts m_ack and m_error together -> x_error=1, x_ack=0.
- timeout_cycles=4, slave silent -> m_access high 4 cycles, then error and timeout pulse; late m_ack 2 cycles later ignored, next transfer unaffected.
- rst asserted during XFER -> next cycle all outputs 0, no ack/error; subsequent simultaneous request grants I first.
